// File: rtl/backprop_sequencer.sv
// Batch controller for backprop_stack: clear, load, propagate, then stream every dC/dW row.
// Optional BACKPROP_SEQ_PERF_EN adds batch_cycles_o / stall_cycles_o performance counters.
//
// state | meaning
// IDLE  | waiting for start_i; latches num_layers_i
// CLEAR | one-cycle stack_reset_o pulse
// FILL  | accepting size*num_layers input beats, layer index fastest
// PROP  | num_layers-1 update_dy_dy_old_o strobes
// CALC  | cal_dc_dw_o strobe for the current (layer,row)
// CAPT  | registering dc_dw_stream_i into the output holding register
// HOLD  | out_valid_o high until the consumer takes the row
// DONE  | done_o (and error_o) pulse, busy_o drops afterwards
module backprop_sequencer #(
    parameter int DATA_SIZE      = 16,
    parameter int SIZE           = 3,
    parameter int MAX_LAYER_SIZE = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_i,
    input  logic [31:0]               num_layers_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      error_o,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output logic [31:0]               in_layer_o,
    output logic                      stack_reset_o,
    output logic                      update_storage_o,
    output logic [31:0]               current_layer_o,
    output logic                      update_dy_dy_old_o,
    output logic                      cal_dc_dw_o,
    output logic [31:0]               dc_dw_layer_o,
    output logic [31:0]               dc_dw_row_o,
    input  logic [DATA_SIZE*SIZE-1:0] dc_dw_stream_i,
    output logic [DATA_SIZE*SIZE-1:0] out_data_o,
    output logic [31:0]               out_layer_o,
    output logic [31:0]               out_row_o,
    output logic                      out_valid_o,
`ifdef BACKPROP_SEQ_PERF_EN
    output logic [31:0]               batch_cycles_o,
    output logic [31:0]               stall_cycles_o,
`endif
    input  logic                      out_ready_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FILL, S_PROP, S_CALC, S_CAPT, S_HOLD, S_DONE
    } state_t;

    localparam logic [31:0] SIZE_M1 = 32'(SIZE - 1);
    localparam logic [31:0] MAX_L   = 32'(MAX_LAYER_SIZE);

    state_t                    state_q, state_d;
    logic [31:0]               nl_q;
    logic                      err_q;
    logic                      busy_q;
    logic [31:0]               l_q, s_q, p_q, lay_q, row_q;
    logic [DATA_SIZE*SIZE-1:0] out_data_q;
    logic [31:0]               out_layer_q, out_row_q;
    logic                      out_valid_q;

    logic legal, last_beat, prop_last, row_last;

    assign legal     = (num_layers_i != 32'd0) && (num_layers_i <= MAX_L);
    assign last_beat = (l_q == nl_q - 32'd1) && (s_q == SIZE_M1);
    assign prop_last = (p_q == nl_q - 32'd2);
    assign row_last  = (row_q == SIZE_M1);

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = legal ? S_CLEAR : S_DONE;
            S_CLEAR: state_d = S_FILL;
            S_FILL:  if (in_valid_i && last_beat)
                         state_d = (nl_q == 32'd1) ? S_CALC : S_PROP;
            S_PROP:  if (prop_last) state_d = S_CALC;
            S_CALC:  state_d = S_CAPT;
            S_CAPT:  state_d = S_HOLD;
            S_HOLD:  if (out_ready_i)
                         state_d = (row_last && lay_q == 32'd0) ? S_DONE : S_CALC;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o         = 1'b0;
        in_layer_o         = 32'd0;
        update_storage_o   = 1'b0;
        current_layer_o    = 32'd0;
        update_dy_dy_old_o = 1'b0;
        cal_dc_dw_o        = 1'b0;
        dc_dw_layer_o      = 32'd0;
        dc_dw_row_o        = 32'd0;
        done_o             = 1'b0;
        error_o            = 1'b0;
        // Stack is held in reset while this block is in reset.
        stack_reset_o      = !reset;
        case (state_q)
            S_CLEAR: stack_reset_o = 1'b1;
            S_FILL: begin
                in_ready_o       = 1'b1;
                in_layer_o       = l_q;
                update_storage_o = in_valid_i;
                current_layer_o  = in_valid_i ? l_q : 32'd0;
            end
            S_PROP: begin
                update_dy_dy_old_o = 1'b1;
                current_layer_o    = nl_q - 32'd1;
            end
            S_CALC: begin
                cal_dc_dw_o   = 1'b1;
                dc_dw_layer_o = lay_q;
                dc_dw_row_o   = row_q;
            end
            S_DONE: begin
                done_o  = 1'b1;
                error_o = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            nl_q        <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            l_q         <= '0;
            s_q         <= '0;
            p_q         <= '0;
            lay_q       <= '0;
            row_q       <= '0;
            out_data_q  <= '0;
            out_layer_q <= '0;
            out_row_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    nl_q   <= num_layers_i;
                    err_q  <= !legal;
                    busy_q <= 1'b1;
                end
                S_CLEAR: begin
                    l_q   <= '0;
                    s_q   <= '0;
                    p_q   <= '0;
                    lay_q <= nl_q - 32'd1;
                    row_q <= '0;
                end
                S_FILL: if (in_valid_i) begin
                    if (l_q == nl_q - 32'd1) begin
                        l_q <= '0;
                        s_q <= s_q + 32'd1;
                    end else begin
                        l_q <= l_q + 32'd1;
                    end
                end
                S_PROP: p_q <= p_q + 32'd1;
                S_CAPT: begin
                    out_data_q  <= dc_dw_stream_i;
                    out_layer_q <= lay_q;
                    out_row_q   <= row_q;
                    out_valid_q <= 1'b1;
                end
                S_HOLD: if (out_ready_i) begin
                    out_valid_q <= 1'b0;
                    if (row_last) begin
                        row_q <= '0;
                        lay_q <= lay_q - 32'd1;
                    end else begin
                        row_q <= row_q + 32'd1;
                    end
                end
                S_DONE: busy_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign out_data_o  = out_data_q;
    assign out_layer_o = out_layer_q;
    assign out_row_o   = out_row_q;
    assign out_valid_o = out_valid_q;

`ifdef BACKPROP_SEQ_PERF_EN
    logic [31:0] batch_q, stall_q;
    logic        stall_now;

    assign stall_now = ((state_q == S_FILL) && !in_valid_i) ||
                       ((state_q == S_HOLD) && !out_ready_i);

    always_ff @(posedge clk) begin
        if (!reset) begin
            batch_q <= '0;
            stall_q <= '0;
        end else if (state_q == S_IDLE && start_i) begin
            batch_q <= '0;
            stall_q <= '0;
        end else begin
            if (busy_q && batch_q != 32'hFFFF_FFFF)    batch_q <= batch_q + 32'd1;
            if (stall_now && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
        end
    end

    assign batch_cycles_o = batch_q;
    assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_backprop_sequencer.sv
// Directed-plus-random bench for backprop_sequencer with a behavioural backprop_stack stand-in.
// Define BACKPROP_SEQ_PERF_EN to also check the performance counters.
module tb_backprop_sequencer;
    localparam int DW   = 16;
    localparam int SZ   = 3;
    localparam int MAXL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   num_layers = '0;
    logic          busy, done, error;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_layer;
    logic          stack_reset, update_storage, update_dy, cal;
    logic [31:0]   current_layer, dc_dw_layer, dc_dw_row;
    logic [DW*SZ-1:0] dc_dw_stream = '0;
    logic [DW*SZ-1:0] out_data;
    logic [31:0]   out_layer, out_row;
    logic          out_valid;
    logic          out_ready = 1'b1;
`ifdef BACKPROP_SEQ_PERF_EN
    logic [31:0]   batch_cycles, stall_cycles;
`endif

    backprop_sequencer #(.DATA_SIZE(DW), .SIZE(SZ), .MAX_LAYER_SIZE(MAXL)) dut (
        .clk                (clk),
        .reset              (rst_n),
        .start_i            (start),
        .num_layers_i       (num_layers),
        .busy_o             (busy),
        .done_o             (done),
        .error_o            (error),
        .in_valid_i         (in_valid),
        .in_ready_o         (in_ready),
        .in_layer_o         (in_layer),
        .stack_reset_o      (stack_reset),
        .update_storage_o   (update_storage),
        .current_layer_o    (current_layer),
        .update_dy_dy_old_o (update_dy),
        .cal_dc_dw_o        (cal),
        .dc_dw_layer_o      (dc_dw_layer),
        .dc_dw_row_o        (dc_dw_row),
        .dc_dw_stream_i     (dc_dw_stream),
        .out_data_o         (out_data),
        .out_layer_o        (out_layer),
        .out_row_o          (out_row),
        .out_valid_o        (out_valid),
`ifdef BACKPROP_SEQ_PERF_EN
        .batch_cycles_o     (batch_cycles),
        .stall_cycles_o     (stall_cycles),
`endif
        .out_ready_i        (out_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Stand-in stack: stores beats by the layer the sequencer names, answers a
    // dC/dW query one cycle later, and drives noise at every other time.
    function automatic logic [DW*SZ-1:0] row_val(input logic [15:0] a0, input logic [15:0] a1,
                                                 input logic [15:0] a2, input int r);
        logic [15:0] e0, e1, e2;
        e0 = a0 + 16'(r * 257);
        e1 = a1 + 16'(r * 257 + 17);
        e2 = a2 + 16'(r * 257 + 34);
        return {e0, e1, e2};
    endfunction

    typedef struct { int l; int r; logic [DW*SZ-1:0] d; } obs_t;

    logic [15:0] beat_data [MAXL][SZ];
    logic [15:0] beat_seq  [MAXL*SZ];
    logic [15:0] mem       [MAXL][SZ];
    int          wcnt      [MAXL];
    int          kbeat, cur_n;
    int          beat_log[$];
    obs_t        obs_q[$];
    int n_dy, dy_bad, n_cal, n_srst, n_done, n_err, excl_err, zero_err, stab_err, stray;
    int gaps, hstall, bcount;
    logic             held = 1'b0;
    logic [DW*SZ+63:0] held_val;
    logic [DW*SZ-1:0]  next_stream = '0;

    always @(negedge clk) begin
        int cl, strobes;
        next_stream = {16'($urandom), 32'($urandom)};
        if (rst_n) begin
            strobes = int'(stack_reset) + int'(update_storage) + int'(update_dy) + int'(cal);
            if (strobes > 1) excl_err++;
            if (stack_reset) n_srst++;
            if ((in_valid && in_ready) != update_storage) stray++;
            if (update_storage) begin
                cl = int'(current_layer);
                beat_log.push_back(cl);
                if (cl < MAXL && wcnt[cl] < SZ && kbeat < MAXL*SZ) mem[cl][wcnt[cl]] = beat_seq[kbeat];
                if (cl < MAXL) wcnt[cl]++;
                kbeat++;
            end
            if (update_dy) begin
                n_dy++;
                if (int'(current_layer) != cur_n - 1) dy_bad++;
            end
            if (!update_storage && !update_dy && current_layer != 0) zero_err++;
            if (!cal && (dc_dw_layer != 0 || dc_dw_row != 0)) zero_err++;
            if (cal) begin
                n_cal++;
                if (dc_dw_layer < MAXL && dc_dw_row < SZ)
                    next_stream = row_val(mem[dc_dw_layer][0], mem[dc_dw_layer][1],
                                          mem[dc_dw_layer][2], int'(dc_dw_row));
            end
            if (out_valid && out_ready) obs_q.push_back('{int'(out_layer), int'(out_row), out_data});
            if (held && out_valid && {out_data, out_layer, out_row} != held_val) stab_err++;
            held     = out_valid && !out_ready;
            held_val = {out_data, out_layer, out_row};
            if (done) begin
                n_done++;
                if (error) n_err++;
            end
            if (in_ready && !in_valid) gaps++;
            if (out_valid && !out_ready) hstall++;
            if (busy) bcount++;
        end else begin
            held = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1 dc_dw_stream = next_stream;
    end

    task automatic clear_logs();
        beat_log.delete();
        obs_q.delete();
        n_dy = 0; dy_bad = 0; n_cal = 0; n_srst = 0; n_done = 0; n_err = 0;
        excl_err = 0; zero_err = 0; stab_err = 0; stray = 0;
        gaps = 0; hstall = 0; bcount = 0; kbeat = 0;
        for (int l = 0; l < MAXL; l++) begin
            wcnt[l] = 0;
            for (int s = 0; s < SZ; s++) mem[l][s] = '0;
        end
    endtask

    task automatic prep_data(input int n);
        cur_n = n;
        for (int l = 0; l < MAXL; l++)
            for (int s = 0; s < SZ; s++) beat_data[l][s] = 16'($urandom);
        for (int k = 0; k < MAXL*SZ; k++)
            beat_seq[k] = (n > 0 && k < n*SZ) ? beat_data[k % n][k / n] : 16'h0;
    endtask

    task automatic run_batch(input int n, input bit gapmode, input bit stallmode, input bit pokemode);
        int cyc, stall_left;
        bit stalled, poked;
        clear_logs();
        prep_data(n);
        stalled = 0; poked = 0; stall_left = 0; cyc = 0;
        @(posedge clk); #1;
        start = 1'b1; num_layers = 32'(n); in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; num_layers = $urandom;
        while (n_done == 0 && cyc < 3000) begin
            in_valid = gapmode ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else if (stallmode && !stalled && out_valid && out_row == 32'd1) begin
                out_ready = 1'b0;
                stalled = 1;
                stall_left = 4;
            end else begin
                out_ready = 1'b1;
            end
            if (pokemode && !poked && cal) begin
                start = 1'b1; num_layers = 32'd1; poked = 1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("batch_timeout", 64'(cyc < 3000), 64'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_batch(input int n);
        bit ok;
        obs_t e;
        ok = (n >= 1 && n <= MAXL);
        check("done_count", 64'(n_done), 64'd1);
        check("error_count", 64'(n_err), ok ? 64'd0 : 64'd1);
        check("exclusive_strobes", 64'(excl_err), 64'd0);
        check("idle_zero_buses", 64'(zero_err), 64'd0);
        check("stable_while_stalled", 64'(stab_err), 64'd0);
        check("stray_beats", 64'(stray), 64'd0);
        check("stack_reset_pulses", 64'(n_srst), ok ? 64'd1 : 64'd0);
        check("beat_count", 64'(beat_log.size()), ok ? 64'(n*SZ) : 64'd0);
        check("dy_count", 64'(n_dy), ok ? 64'(n-1) : 64'd0);
        check("dy_layer", 64'(dy_bad), 64'd0);
        check("cal_count", 64'(n_cal), ok ? 64'(n*SZ) : 64'd0);
        check("output_count", 64'(obs_q.size()), ok ? 64'(n*SZ) : 64'd0);
        if (ok) begin
            for (int k = 0; k < beat_log.size() && k < n*SZ; k++)
                check($sformatf("beat_layer[%0d]", k), 64'(beat_log[k]), 64'(k % n));
            for (int i = 0; i < obs_q.size() && i < n*SZ; i++) begin
                e.l = n - 1 - i / SZ;
                e.r = i % SZ;
                e.d = row_val(beat_data[e.l][0], beat_data[e.l][1], beat_data[e.l][2], e.r);
                check($sformatf("out_layer[%0d]", i), 64'(obs_q[i].l), 64'(e.l));
                check($sformatf("out_row[%0d]", i), 64'(obs_q[i].r), 64'(e.r));
                check($sformatf("out_data[%0d]", i), 64'(obs_q[i].d), 64'(e.d));
            end
        end
`ifdef BACKPROP_SEQ_PERF_EN
        check("batch_cycles", 64'(batch_cycles), 64'(bcount));
        check("stall_cycles", 64'(stall_cycles), 64'(gaps + hstall));
`endif
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_stack_reset"}, 64'(stack_reset), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_strobes"}, 64'({update_storage, update_dy, cal}), 64'd0);
    endtask

    initial begin
        int cyc;
        clear_logs();
        prep_data(1);

        // Power-on reset.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_stack_reset", 64'(stack_reset), 64'd0);

        // Illegal layer counts: done and error together right after acceptance.
        for (int t = 0; t < 2; t++) begin
            int n;
            n = (t == 0) ? 0 : MAXL + 1;
            clear_logs();
            prep_data(n);
            start = 1'b1; num_layers = 32'(n);
            @(posedge clk); #1;
            start = 1'b0;
            check($sformatf("illegal%0d_done", n), 64'(done), 64'd1);
            check($sformatf("illegal%0d_error", n), 64'(error), 64'd1);
            check($sformatf("illegal%0d_busy", n), 64'(busy), 64'd1);
            @(posedge clk); #1;
            check($sformatf("illegal%0d_done_clear", n), 64'(done), 64'd0);
            check($sformatf("illegal%0d_busy_clear", n), 64'(busy), 64'd0);
            repeat (2) @(posedge clk);
            #1;
            check_batch(n);
        end

        // Two layers, no back-pressure.
        run_batch(2, 0, 0, 0);
        check_batch(2);

        // Single layer: propagation is skipped.
        run_batch(1, 0, 0, 0);
        check_batch(1);

        // Random input gaps plus a 5-cycle output stall at row 1.
        run_batch(3, 1, 1, 0);
        check_batch(3);
        check("hold_stall_cycles", 64'(hstall), 64'd5);
`ifdef BACKPROP_SEQ_PERF_EN
        check("stall_gaps_plus_5", 64'(stall_cycles), 64'(gaps + 5));
        repeat (4) @(posedge clk);
        #1;
        check("batch_cycles_frozen", 64'(batch_cycles), 64'(bcount));
`endif

        // Start pulsed while busy in CALC is ignored.
        run_batch(4, 1, 0, 1);
        check_batch(4);

        // Reset in the middle of propagation.
        clear_logs();
        prep_data(4);
        start = 1'b1; num_layers = 32'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!update_dy && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reach_prop", 64'(update_dy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("midreset_hold");
        rst_n = 1'b1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midreset_no_done", 64'(n_done), 64'd0);
        check("midreset_idle_busy", 64'(busy), 64'd0);

        run_batch(2, 1, 0, 0);
        check_batch(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end
endmodule
